apb_master: RTL and testbench
=============================

// Module: apb_master
// PURPOSE
//  Single-outstanding APB3 initiator. Converts a valid/ready request / response pair from a core-side
//  agent into APB SETUP/ACCESS transfers that drive the slave port of an apb_node. Bounds slave wait
//  states with a programmable timeout and returns read data and error per transfer.
// PARAMETERS
//  APB_ADDR_WIDTH  32  address width, paddr_o and req_addr_i
//  APB_DATA_WIDTH  32  data width, pwdata_o / prdata_i / req_wdata_i / rsp_rdata_o
//  TIMEOUT_CYCLES  256 max ACCESS cycles with pready_i low before abort; 0 disables timeout
// PORTS
//  clk_i        in  1   clock, all logic on rising edge
//  rst_i        in  1   synchronous reset, active-high
//  req_valid_i  in  1   request present
//  req_ready_o  out 1   request accepted when valid&&ready
//  req_write_i  in  1   1=write, 0=read
//  req_addr_i   in  AW  transfer address
//  req_wdata_i  in  DW  write data (ignored for reads)
//  rsp_valid_o  out 1   response present; held until rsp_ready_i
//  rsp_ready_i  in  1   response consumed when valid&&ready
//  rsp_rdata_o  out DW  read data; 0 for writes and errors
//  rsp_err_o    out 1   pslverr_i captured, or timeout
//  timeout_o    out 1   one-cycle pulse when a transfer is aborted by timeout
//  psel_o       out 1   APB select
//  penable_o    out 1   APB enable
//  pwrite_o     out 1   APB direction
//  paddr_o      out AW  APB address
//  pwdata_o     out DW  APB write data
//  prdata_i     in  DW  APB read data
//  pready_i     in  1   APB ready
//  pslverr_i    in  1   APB slave error
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0 (psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_*, timeout_o);
//    counter 0. Reset mid-transfer drops psel_o/penable_o the next cycle and discards the in-flight transfer.
//  - FSM IDLE -> SETUP -> ACCESS -> IDLE. All APB outputs are registered.
//  - req_ready_o = (state==IDLE) && (!rsp_valid_o || rsp_ready_i). This is a combinational path from
//    rsp_ready_i; no other input-to-output paths.
//  - Accept (cycle 0 edge): latch write/addr/wdata. pwdata_o = req_wdata_i for writes, 0 for reads.
//  - SETUP (cycle 1): psel_o=1, penable_o=0. ACCESS (cycle 2+): psel_o=1, penable_o=1.
//  - paddr/pwrite/pwdata are stable from SETUP through the last ACCESS cycle.
//  - ACCESS with pready_i=1: capture rsp_err_o=pslverr_i. rsp_rdata_o=prdata_i if read and !pslverr_i, else 0.
//    Set rsp_valid_o the next cycle and return to IDLE. psel_o/penable_o=0 in that cycle.
//  - Minimum latency accept->rsp_valid_o = 3 cycles. Peak throughput is 1 transfer per 3 cycles.
//  - Timeout: counter clears on entering ACCESS and increments each ACCESS cycle with pready_i=0.
//    When TIMEOUT_CYCLES!=0 and the counter == TIMEOUT_CYCLES-1 with pready_i=0:
//    abort -> IDLE, rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0, timeout_o=1 for one cycle.
//    pready_i=1 in the same cycle as the limit wins, giving a normal completion.
//  - Counter width $clog2(TIMEOUT_CYCLES+1), minimum 1. It never wraps.
//  - The response register holds its value while rsp_valid_o && !rsp_ready_i. No new request is accepted
//    in that state. Consume and accept may occur in the same cycle.
//  - pready_i/pslverr_i/prdata_i are ignored outside ACCESS.
// STRUCTURE
//  - apb_pkg: apb_state_e {IDLE,SETUP,ACCESS}; typedefs apb_req_t {write,addr,wdata} and
//    apb_rsp_t {rdata,err}, parameterised by width localparams.
//  - One sub-module: apb_timeout_cnt (clear, enable, limit -> expired). Instantiated even when
//    TIMEOUT_CYCLES=0, with expired tied low.
// TESTING
//  1 write 0x1A00_0004 / 0xDEADBEEF, pready_i=1 at once -> SETUP c1, ACCESS c2 (pwrite_o=1),
//    rsp_valid_o c3, err=0, rdata=0.
//  2 read 0x1A00_0010, slave inserts 3 wait states, prdata_i=0x1234_5678 -> ACCESS lasts 4 cycles,
//    addr stable, rsp_rdata_o=0x1234_5678.
//  3 read with pslverr_i=1, prdata_i=0xFFFF_FFFF -> rsp_err_o=1, rsp_rdata_o=0, no timeout_o.
//  4 TIMEOUT_CYCLES=4, pready_i stuck 0 -> abort after 4th ACCESS cycle, timeout_o 1-cycle pulse,
//    rsp_err_o=1. A second run with pready_i=1 on cycle 4 completes normally.
//  5 rsp_ready_i=0 for 5 cycles with req_valid_i=1 -> req_ready_o=0 and response held.
//    rsp_ready_i=1 -> same-cycle accept, next SETUP the following cycle.
//  6 rst_i asserted during ACCESS -> next cycle psel_o=penable_o=rsp_valid_o=0, FSM IDLE,
//    no response for the aborted transfer.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types for the APB3 initiator: FSM encoding, request/response records and
// the timeout counter width helper.
package apb_pkg;

   localparam int unsigned APB_AW = 32;
   localparam int unsigned APB_DW = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   typedef struct packed {
      logic              write;
      logic [APB_AW-1:0] addr;
      logic [APB_DW-1:0] wdata;
   } apb_req_t;

   typedef struct packed {
      logic [APB_DW-1:0] rdata;
      logic              err;
   } apb_rsp_t;

   // Width able to hold 0..limit; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned limit);
      int unsigned w;
      w = $clog2(limit + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state counter for the ACCESS phase. Saturates instead of wrapping; expired_o
// flags the last permitted wait cycle. A LIMIT of 0 disables expiry entirely.
module apb_timeout_cnt
   import apb_pkg::*;
#(
   parameter int unsigned LIMIT = 256
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW = cnt_width(LIMIT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CW'(LIMIT))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   generate
      if (LIMIT == 0) begin : g_off
         assign expired_o = 1'b0;
      end else begin : g_on
         assign expired_o = (cnt_q == CW'(LIMIT - 1));
      end
   endgenerate

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB3 initiator: one core-side request becomes one SETUP/ACCESS
// transfer, with a bounded wait-state budget and a held response register.
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned APB_ADDR_WIDTH = APB_AW,
   parameter int unsigned APB_DATA_WIDTH = APB_DW,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic                      req_write_i,
   input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
   input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      timeout_o,
   output logic                      psel_o,
   output logic                      penable_o,
   output logic                      pwrite_o,
   output logic [APB_ADDR_WIDTH-1:0] paddr_o,
   output logic [APB_DATA_WIDTH-1:0] pwdata_o,
   input  logic [APB_DATA_WIDTH-1:0] prdata_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i,
   output apb_state_e                dbg_state_o
);

   apb_state_e state_q, state_d;
   apb_req_t   req_q, req_d;
   apb_rsp_t   rsp_q, rsp_d;
   logic       psel_q, psel_d;
   logic       penable_q, penable_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       timeout_q, timeout_d;
   logic       cnt_clear, cnt_en, cnt_expired;

   // Handshakes: a beat transfers on the rising edge where valid && ready are both high;
   // valid never waits for ready, and rsp_valid_o stays high with stable data until taken.
   // The only combinational input-to-output path is rsp_ready_i -> req_ready_o.
   assign req_ready_o = (state_q == IDLE) && (!rsp_valid_q || rsp_ready_i);

   assign cnt_clear = (state_q == SETUP);
   assign cnt_en    = (state_q == ACCESS) && !pready_i;

   apb_timeout_cnt #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (cnt_clear),
      .en_i      (cnt_en),
      .expired_o (cnt_expired)
   );

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      rsp_d       = rsp_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      timeout_d   = 1'b0;
      rsp_valid_d = rsp_valid_q && !rsp_ready_i;

      case (state_q)
         IDLE: begin
            if (req_valid_i && req_ready_o) begin
               req_d.write = req_write_i;
               req_d.addr  = req_addr_i;
               req_d.wdata = req_write_i ? req_wdata_i : '0;
               psel_d      = 1'b1;
               penable_d   = 1'b0;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            // A slave completing on the limit cycle takes priority over the abort.
            if (pready_i) begin
               rsp_d.err   = pslverr_i;
               rsp_d.rdata = (!req_q.write && !pslverr_i) ? prdata_i : '0;
               rsp_valid_d = 1'b1;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = IDLE;
            end else if (cnt_expired) begin
               rsp_d.err   = 1'b1;
               rsp_d.rdata = '0;
               rsp_valid_d = 1'b1;
               timeout_d   = 1'b1;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         req_q       <= '0;
         rsp_q       <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         rsp_q       <= rsp_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         timeout_q   <= timeout_d;
      end
   end

   assign psel_o      = psel_q;
   assign penable_o   = penable_q;
   assign pwrite_o    = req_q.write;
   assign paddr_o     = req_q.addr;
   assign pwdata_o    = req_q.wdata;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_q.rdata;
   assign rsp_err_o   = rsp_q.err;
   assign timeout_o   = timeout_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed and randomized transfers against a per-transfer outcome model
// (wait count vs. timeout budget decides latency, error and read data).
module tb_apb_master;
   import apb_pkg::*;

   localparam int TO = 4;
   localparam int EW = 42;   // {timeout, err, rdata[31:0], access_cycles[7:0]}

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_write_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        timeout_o;
   logic        psel_o;
   logic        penable_o;
   logic        pwrite_o;
   logic [31:0] paddr_o;
   logic [31:0] pwdata_o;
   logic [31:0] prdata_i;
   logic        pready_i;
   logic        pslverr_i;
   apb_state_e  dbg_state_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] last_exp;

   logic        cur_write;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic [31:0] cur_rdata;
   int          cur_waits;
   logic        cur_slverr;

   apb_master #(
      .APB_ADDR_WIDTH (32),
      .APB_DATA_WIDTH (32),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_write_i (req_write_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .timeout_o   (timeout_o),
      .psel_o      (psel_o),
      .penable_o   (penable_o),
      .pwrite_o    (pwrite_o),
      .paddr_o     (paddr_o),
      .pwdata_o    (pwdata_o),
      .prdata_i    (prdata_i),
      .pready_i    (pready_i),
      .pslverr_i   (pslverr_i),
      .dbg_state_o (dbg_state_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // A slave that holds pready low for `waits` ACCESS cycles answers on cycle waits+1,
   // unless that exceeds the TO-cycle budget, in which case the transfer is aborted.
   function automatic logic [EW-1:0] model(input logic wr, input int waits,
                                           input logic se, input logic [31:0] rd);
      if (TO != 0 && waits >= TO)
         return {1'b1, 1'b1, 32'h0, 8'(TO)};
      return {1'b0, se, (!wr && !se) ? rd : 32'h0, 8'(waits + 1)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            input int waits, input logic se, input logic [31:0] rd);
      cur_write   = wr;
      cur_addr    = addr;
      cur_wdata   = wd;
      cur_waits   = waits;
      cur_slverr  = se;
      cur_rdata   = rd;
      req_valid_i = 1'b1;
      req_write_i = wr;
      req_addr_i  = addr;
      req_wdata_i = wd;
      exp_q.push_back(model(wr, waits, se, rd));
   endtask

   // Waits for req_ready_o, lets the accept edge pass, returns in the SETUP cycle.
   task automatic accept_req();
      int k;
      k = 0;
      #1;
      while (!req_ready_o && k < 50) begin
         @(posedge clk_i); #1;
         k++;
      end
      checks++;
      if (req_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL accept_wait: req_ready_o=%b required 1 within 50 cycles", req_ready_o);
      end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      req_write_i = 1'($urandom_range(0, 1));
      req_addr_i  = $urandom;
      req_wdata_i = $urandom;
      checks++;
      if ({rsp_valid_o, timeout_o} !== 2'b00) begin
         failures++;
         $display("FAIL setup_rsp_idle: rsp_valid/timeout=%b required 00", {rsp_valid_o, timeout_o});
      end
   endtask

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic se, input logic [31:0] rd);
      drive_req(wr, addr, wd, waits, se, rd);
      accept_req();
   endtask

   // Acts as the APB slave from the SETUP cycle to the response cycle and checks both.
   task automatic complete();
      logic [EW-1:0] e;
      logic [31:0]   exp_wd;
      int            n;
      bit            fin;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty: queue size 0 required >0");
         return;
      end
      e        = exp_q.pop_front();
      last_exp = e;
      exp_wd   = cur_write ? cur_wdata : 32'h0;
      checks++;
      if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o} !== {1'b1, 1'b0, cur_write, cur_addr, exp_wd}) begin
         failures++;
         $display("FAIL setup_phase: got sel=%b en=%b wr=%b addr=%h wd=%h required 1 0 %b %h %h",
                  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, cur_write, cur_addr, exp_wd);
      end
      pready_i  = 1'($urandom_range(0, 1));
      pslverr_i = 1'($urandom_range(0, 1));
      prdata_i  = $urandom;
      n   = 0;
      fin = 0;
      while (!fin && n < 20) begin
         @(posedge clk_i); #1;
         if (rsp_valid_o) begin
            fin = 1;
         end else begin
            n++;
            checks++;
            if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, timeout_o} !==
                {1'b1, 1'b1, cur_write, cur_addr, exp_wd, 1'b0}) begin
               failures++;
               $display("FAIL access_phase: cycle %0d got sel=%b en=%b wr=%b addr=%h wd=%h to=%b",
                        n, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, timeout_o);
            end
            if (n == cur_waits + 1) begin
               pready_i  = 1'b1;
               pslverr_i = cur_slverr;
               prdata_i  = cur_rdata;
            end else begin
               pready_i  = 1'b0;
               pslverr_i = 1'($urandom_range(0, 1));
               prdata_i  = $urandom;
            end
         end
      end
      pready_i  = 1'($urandom_range(0, 1));
      pslverr_i = 1'($urandom_range(0, 1));
      prdata_i  = $urandom;
      checks++;
      if (!fin) begin
         failures++;
         $display("FAIL rsp_wait: no rsp_valid_o after %0d ACCESS cycles", n);
      end
      checks++;
      if (8'(n) !== e[7:0]) begin
         failures++;
         $display("FAIL access_len: got %0d ACCESS cycles required %0d", n, e[7:0]);
      end
      checks++;
      if ({timeout_o, rsp_err_o, rsp_rdata_o, psel_o, penable_o} !== {e[41], e[40], e[39:8], 2'b00}) begin
         failures++;
         $display("FAIL response: got to=%b err=%b rdata=%h sel=%b en=%b required to=%b err=%b rdata=%h sel=0 en=0",
                  timeout_o, rsp_err_o, rsp_rdata_o, psel_o, penable_o, e[41], e[40], e[39:8]);
      end
   endtask

   // Keeps the response stalled for k cycles, then releases rsp_ready_i.
   task automatic hold_rsp(input int k);
      rsp_ready_i = 1'b0;
      #1;
      for (int i = 0; i < k; i++) begin
         if (i > 0) begin
            checks++;
            if (timeout_o !== 1'b0) begin
               failures++;
               $display("FAIL timeout_pulse: timeout_o=%b required 0 while held", timeout_o);
            end
         end
         checks++;
         if ({rsp_valid_o, rsp_err_o, rsp_rdata_o, req_ready_o} !== {1'b1, last_exp[40], last_exp[39:8], 1'b0}) begin
            failures++;
            $display("FAIL rsp_hold: got v=%b err=%b rdata=%h rdy=%b required 1 %b %h 0",
                     rsp_valid_o, rsp_err_o, rsp_rdata_o, req_ready_o, last_exp[40], last_exp[39:8]);
         end
         @(posedge clk_i); #1;
      end
      rsp_ready_i = 1'b1;
   endtask

   task automatic drain();
      rsp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      checks++;
      if ({rsp_valid_o, timeout_o, psel_o, penable_o} !== 4'b0000 || dbg_state_o !== IDLE) begin
         failures++;
         $display("FAIL drain: got v=%b to=%b sel=%b en=%b state=%0d required 0 0 0 0 IDLE",
                  rsp_valid_o, timeout_o, psel_o, penable_o, dbg_state_o);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_i       = 1'b1;
      req_valid_i = 1'b1;
      req_write_i = 1'b1;
      req_addr_i  = $urandom;
      req_wdata_i = $urandom;
      rsp_ready_i = 1'b0;
      pready_i    = 1'b1;
      pslverr_i   = 1'b1;
      prdata_i    = $urandom;
      repeat (3) @(posedge clk_i);
      #1;
      checks++;
      if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, timeout_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: sel=%b en=%b wr=%b addr=%h wd=%h v=%b err=%b rd=%h to=%b required all 0",
                  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, timeout_o);
      end
      checks++;
      if (dbg_state_o !== IDLE || req_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_state: state=%0d rdy=%b required IDLE 1", dbg_state_o, req_ready_o);
      end
      req_valid_i = 1'b0;
      rst_i       = 1'b0;
      rsp_ready_i = 1'b1;
      pready_i    = 1'b0;
      @(posedge clk_i); #1;
      checks++;
      if ({psel_o, penable_o, rsp_valid_o, timeout_o} !== 4'b0000) begin
         failures++;
         $display("FAIL post_reset_idle: sel/en/v/to=%b required 0000", {psel_o, penable_o, rsp_valid_o, timeout_o});
      end
   endtask

   task automatic test_write();
      issue(1'b1, 32'h1A00_0004, 32'hDEAD_BEEF, 0, 1'b0, $urandom);
      complete();
      drain();
   endtask

   task automatic test_read_waits();
      issue(1'b0, 32'h1A00_0010, $urandom, 3, 1'b0, 32'h1234_5678);
      complete();
      drain();
   endtask

   task automatic test_slverr();
      issue(1'b0, 32'h1A00_0020, $urandom, $urandom_range(0, 2), 1'b1, 32'hFFFF_FFFF);
      complete();
      drain();
   endtask

   task automatic test_timeout();
      issue(1'b0, 32'h1A00_0030, $urandom, 50, 1'b0, $urandom);
      complete();
      drain();
      issue(1'b1, 32'h1A00_0034, $urandom, TO - 1, 1'b0, $urandom);
      complete();
      drain();
   endtask

   task automatic test_backpressure();
      rsp_ready_i = 1'b0;
      issue(1'b0, 32'h1A00_0040, $urandom, 1, 1'b0, $urandom);
      complete();
      drive_req(1'b1, 32'h1A00_0044, $urandom, 0, 1'b0, $urandom);
      hold_rsp(5);
      #1;
      checks++;
      if (req_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL consume_accept: req_ready_o=%b required 1 with rsp_ready_i=1", req_ready_o);
      end
      accept_req();
      complete();
      drain();
   endtask

   task automatic test_back_to_back();
      int s;
      rsp_ready_i = 1'b1;
      issue(1'b1, $urandom, $urandom, 0, 1'b0, $urandom);
      s = cyc;
      complete();
      for (int i = 0; i < 3; i++) begin
         issue(1'($urandom_range(0, 1)), $urandom, $urandom, 0, 1'($urandom_range(0, 1)), $urandom);
         complete();
      end
      checks++;
      if (cyc - s !== 11) begin
         failures++;
         $display("FAIL throughput: 4 transfers took %0d cycles SETUP->last rsp, required 11", cyc - s);
      end
      drain();
   endtask

   task automatic test_random();
      rsp_ready_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
         issue(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 5),
               1'($urandom_range(0, 3) == 0), $urandom);
         rsp_ready_i = 1'($urandom_range(0, 1));
         complete();
         if (rsp_ready_i == 1'b0) hold_rsp($urandom_range(1, 3));
      end
      drain();
   endtask

   task automatic test_reset_mid();
      rsp_ready_i = 1'b1;
      issue(1'b0, 32'h1A00_0050, $urandom, 10, 1'b0, $urandom);
      pready_i = 1'b0;
      @(posedge clk_i); #1;
      checks++;
      if ({psel_o, penable_o} !== 2'b11) begin
         failures++;
         $display("FAIL mid_access: sel/en=%b required 11", {psel_o, penable_o});
      end
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      checks++;
      if ({psel_o, penable_o, rsp_valid_o, timeout_o, paddr_o} !== '0 || dbg_state_o !== IDLE) begin
         failures++;
         $display("FAIL mid_reset: sel=%b en=%b v=%b to=%b addr=%h state=%0d required zeros IDLE",
                  psel_o, penable_o, rsp_valid_o, timeout_o, paddr_o, dbg_state_o);
      end
      rst_i = 1'b0;
      void'(exp_q.pop_front());
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_i); #1;
         checks++;
         if ({rsp_valid_o, psel_o} !== 2'b00) begin
            failures++;
            $display("FAIL aborted_silent: v/sel=%b required 00", {rsp_valid_o, psel_o});
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_write();
      test_read_waits();
      test_slverr();
      test_timeout();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_left: %0d entries pending required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
